// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared FSM states and constants for the instruction fetch unit
package fetch_unit_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request instruction fetch feeding the IF/ID slot
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_ir
);
  state_t state, state_nx;
  logic [31:0] pc, hold_buf;
  logic slot_free, accept, load, capture;
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc & 32'hFFFF_FFFC;
  assign slot_free = !ifid_valid || !stall;
  assign accept    = imem_req_valid && imem_req_ready;
  assign load      = !redirect_valid && slot_free &&
                     ((state == S_WAIT && imem_resp_valid) || state == S_HOLD);
  assign capture   = !redirect_valid && !slot_free && state == S_WAIT && imem_resp_valid;
  // Next state: a redirect drops whatever is in flight; an accepted-but-unanswered
  // request must still be drained in S_DROP so only one request is ever outstanding.
  always_comb begin
    state_nx = state;
    case (state)
      S_REQ:   state_nx = accept ? (redirect_valid ? S_DROP : S_WAIT) : S_REQ;
      S_WAIT:  state_nx = imem_resp_valid ? ((redirect_valid || slot_free) ? S_REQ : S_HOLD)
                                          : (redirect_valid ? S_DROP : S_WAIT);
      S_HOLD:  state_nx = (redirect_valid || slot_free) ? S_REQ : S_HOLD;
      S_DROP:  state_nx = imem_resp_valid ? S_REQ : S_DROP;
      default: state_nx = S_REQ;
    endcase
  end
  // State, pc, hold buffer and IF/ID slot; redirect flushes ahead of any load or stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold_buf   <= '0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_ir    <= NOP;
    end else begin
      state <= state_nx;
      if (capture) hold_buf <= imem_resp_data;
      if (redirect_valid) begin
        pc         <= redirect_pc & 32'hFFFF_FFFC;
        ifid_valid <= 1'b0;
        ifid_ir    <= NOP;
      end else if (load) begin
        pc         <= pc + 32'd4;
        ifid_valid <= 1'b1;
        ifid_pc    <= pc;
        ifid_ir    <= (state == S_HOLD) ? hold_buf : imem_resp_data;
      end else if (!stall) begin
        ifid_valid <= 1'b0;
      end
    end
  end
endmodule
